// File: rtl/ujtag_bus_bridge.sv
// ujtag_bus_bridge: clk-domain bridge from the UJTAG user strobes to a simple register bus.
// The UJTAG inputs are oversampled through a 2-FF synchronizer and a third edge-detect stage.
// A shared 49-bit shift register implements the command DR (IR_CMD) and the 35-bit status DR
// (IR_STAT). Update-DR on the command DR issues one bus read or write.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   UIREG, URSTB                user instruction, user reset (active low)
//   UDRCAP, UDRSH, UDRUPD       Capture-/Shift-/Update-DR indicators
//   UDRCK, UTDI, UTDO           user DR clock, serial in, serial out (registered)
//   bus_req/write/addr/wdata    request held until bus_ack or timeout; fields stable meanwhile
//   bus_ack, bus_rdata          completion strobe; read data valid with bus_ack
module ujtag_bus_bridge #(
    parameter logic [7:0]  IR_CMD  = 8'h22,
    parameter logic [7:0]  IR_STAT = 8'h23,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  UIREG,
    input  logic        URSTB,
    input  logic        UDRCAP,
    input  logic        UDRSH,
    input  logic        UDRUPD,
    input  logic        UDRCK,
    input  logic        UTDI,
    output logic        UTDO,
    output logic        bus_req,
    output logic        bus_write,
    output logic [15:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CMD_W  = 49;
    localparam int unsigned STAT_W = 35;
    localparam int unsigned SYN_W  = 14;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    logic [SYN_W-1:0]  w_pins;
    logic [SYN_W-1:0]  r_sync1;
    logic [SYN_W-1:0]  r_sync2;
    logic [SYN_W-1:0]  r_sync3;
    logic              r_ck_rise;
    logic              r_upd_rise;

    logic [7:0]        w_ir;
    logic              w_rstb;
    logic              w_cap;
    logic              w_sh;
    logic              w_tdi;
    logic              w_is_cmd;
    logic              w_is_stat;
    logic              w_upd_cmd;
    logic              w_busy;

    logic [CMD_W-1:0]  r_sr;
    logic [CMD_W-1:0]  w_sr_next;
    logic              r_tdo;
    logic              w_tdo_next;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_drop;
    logic              w_ack;
    logic              w_expire;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_bus_write;
    logic [15:0]       r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [31:0]       r_rdata;
    logic              r_timeout;
    logic              r_overrun;

    assign w_pins = {UIREG, URSTB, UDRCAP, UDRSH, UDRUPD, UDRCK, UTDI};

    // Levels come from stage 3 so they line up with the registered edge pulses.
    assign w_ir      = r_sync3[13:6];
    assign w_rstb    = r_sync3[5];
    assign w_cap     = r_sync3[4];
    assign w_sh      = r_sync3[3];
    assign w_tdi     = r_sync3[0];
    assign w_is_cmd  = (w_ir == IR_CMD);
    assign w_is_stat = (w_ir == IR_STAT);
    assign w_upd_cmd = r_upd_rise & w_is_cmd;
    assign w_busy    = (r_state == S_REQ);

    // Synchronizer, edge-detect stage and registered edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= '0;
            r_ck_rise  <= 1'b0;
            r_upd_rise <= 1'b0;
        end else begin
            r_sync1    <= w_pins;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_ck_rise  <= r_sync2[1] & ~r_sync3[1];
            r_upd_rise <= r_sync2[2] & ~r_sync3[2];
        end
    end

    // Shared DR: capture/shift at the active length; UTDO follows the new sr[0].
    always_comb begin
        w_sr_next  = r_sr;
        w_tdo_next = 1'b0;
        if (!w_rstb) begin
            w_sr_next = '0;
        end else if (r_ck_rise) begin
            if (w_is_cmd) begin
                if (w_cap) begin
                    w_sr_next = {r_bus_write, r_bus_addr, r_bus_wdata};
                end else if (w_sh) begin
                    w_sr_next = {w_tdi, r_sr[CMD_W-1:1]};
                end
            end else if (w_is_stat) begin
                if (w_cap) begin
                    w_sr_next[STAT_W-1:0] = {r_overrun, r_timeout, w_busy, r_rdata};
                end else if (w_sh) begin
                    w_sr_next[STAT_W-1:0] = {w_tdi, r_sr[STAT_W-1:1]};
                end
            end
        end
        if (w_rstb && (w_is_cmd || w_is_stat)) begin
            w_tdo_next = w_sr_next[0];
        end
    end

    // Bus FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus FSM next state; an update seen in REQ is dropped even if ack lands the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_ack        = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_upd_cmd) begin
                    w_accept     = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_drop = w_upd_cmd;
                if (bus_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_expire     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift register, command fields, status flags and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_tdo       <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sr  <= w_sr_next;
            r_tdo <= w_tdo_next;
            if (w_accept) begin
                r_bus_write <= r_sr[48];
                r_bus_addr  <= r_sr[47:32];
                r_bus_wdata <= r_sr[31:0];
                r_timeout   <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_ack && !r_bus_write) begin
                r_rdata <= bus_rdata;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
            if ((r_state == S_REQ) && (w_state_next == S_REQ)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign UTDO      = r_tdo;
    assign bus_req   = w_busy;
    assign bus_write = r_bus_write;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule
